// File: rtl/spar_loader_pkg.sv
// Shared definitions for the tile BRAM loader.
//   OP_LOAD / OP_DUMP : values of cmd_op
//   loader_state_e    : loader FSM state encoding
//   BRAM_ADDR_W/DATA_W: geometry of one PE block BRAM (1024 x 16)
package spar_loader_pkg;

  localparam int BRAM_ADDR_W = 10;
  localparam int BRAM_DATA_W = 16;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DUMP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/loader_skid_fifo.sv
// Two-entry FIFO that buffers BRAM read data for the DUMP output stream.
// All outputs are registers, so out_data never glitches with out_ready.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write one word (may coincide with pop, also when full)
//   pop        : remove the head word (never while empty)
//   dout       : head word, stable until popped
//   valid      : FIFO holds at least one word
//   count      : number of stored words, 0..2
module loader_skid_fifo
  import spar_loader_pkg::*;
#(
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= din;
          else                 tail_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_q <= din;
          end else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // The issue throttle in the loader guarantees neither of these can occur.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && count_q == 2'd0));
      assert (!(push && !pop && count_q == 2'd2));
    end
  end

  assign dout  = head_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/tile_bram_loader.sv
// Host-side DMA stage in front of the PE tile's external BRAM port.
// LOAD streams 16-bit words into one PE block's BRAM through port A;
// DUMP reads a BRAM region through port B and streams it out.
// While busy=1 the loader owns the tile BRAM mux (external=1).
//   cmd_*        : command handshake (op, block row/col, base address, length)
//   in_*         : LOAD word stream (valid/ready)
//   out_*        : DUMP word stream (valid/ready), registered via a 2-entry FIFO
//   external     : tile BRAM mux select, high from accept through DONE
//   BRAM_i/j     : latched target block
//   WEA/ADDRA/DIA: registered port-A write, one cycle per accepted word
//   ADDRB / DOB  : port-B read address and read data (one-cycle latency)
//   WEB / DIB    : tied off, port B is read-only here
//   busy/done/err: status; done and err are single-cycle pulses
module tile_bram_loader
  import spar_loader_pkg::*;
#(
  parameter int TILE_DIM = 1,
  parameter int ADDR_W   = BRAM_ADDR_W,
  parameter int DATA_W   = BRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_bi,
  input  logic [7:0]        cmd_bj,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              external,
  output logic [7:0]        BRAM_i,
  output logic [7:0]        BRAM_j,
  output logic              WEA,
  output logic              WEB,
  output logic [ADDR_W-1:0] ADDRA,
  output logic [ADDR_W-1:0] ADDRB,
  output logic [DATA_W-1:0] DIA,
  output logic [DATA_W-1:0] DIB,
  input  logic [DATA_W-1:0] DOB,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [8:0]      TILE_DIM_W = 9'(TILE_DIM);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;      // next word address, wraps mod 2^ADDR_W
  logic [ADDR_W:0]   rem_q;       // words still to accept (LOAD) or issue (DUMP)
  logic [7:0]        bi_q, bj_q;
  logic              wea_q;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dia_q;
  logic              err_q;
  logic              vld_p1;      // a port-B read was issued last cycle

  logic              cmd_fire, cmd_bad, cmd_start;
  logic              in_fire;
  logic              issue;
  logic              fifo_pop;
  logic [1:0]        fifo_count;
  logic [2:0]        occ_next;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_bad   = ({1'b0, cmd_bi} >= TILE_DIM_W) || ({1'b0, cmd_bj} >= TILE_DIM_W);
  assign cmd_start = cmd_fire && !cmd_bad && (cmd_len != '0);
  assign in_fire   = in_valid && in_ready;
  assign fifo_pop  = out_valid && out_ready;

  // FIFO occupancy one cycle from now, counting the read already in flight.
  // Including this cycle's pop is what allows one issue per cycle while
  // the consumer keeps up, without ever overrunning the 2 entries.
  assign occ_next = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, fifo_pop};
  assign issue    = (state_q == ST_DUMP) && (rem_q != '0) && (occ_next < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_fire && !cmd_bad) begin
          if (cmd_len == '0)          state_d = ST_DONE;
          else if (cmd_op == OP_LOAD) state_d = ST_LOAD;
          else                        state_d = ST_DUMP;
        end
      end
      ST_LOAD: begin
        // With nothing left to accept, this cycle carries the final WEA
        // so that DONE itself never writes.
        in_ready = (rem_q != '0);
        if (rem_q == '0) state_d = ST_DONE;
      end
      ST_DUMP: begin
        if (issue && rem_q == LEN_ONE) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as soon as the last word is being popped, so done
        // lands in the cycle right after the final beat.
        if (!vld_p1 && (fifo_count == 2'd0 || (fifo_count == 2'd1 && fifo_pop)))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      rem_q   <= '0;
      bi_q    <= '0;
      bj_q    <= '0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dia_q   <= '0;
      err_q   <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      err_q  <= cmd_fire && cmd_bad;
      wea_q  <= in_fire;
      vld_p1 <= issue;
      if (in_fire) begin
        addra_q <= addr_q;
        dia_q   <= in_data;
      end
      if (cmd_start) begin
        addr_q <= cmd_base;
        rem_q  <= cmd_len;
        bi_q   <= cmd_bi;
        bj_q   <= cmd_bj;
      end else if (in_fire || issue) begin
        addr_q <= addr_q + ADDR_ONE;
        rem_q  <= rem_q - LEN_ONE;
      end
    end
  end

  // ---- read-data stage: DOB captured one cycle after issue ----
  loader_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_p1),
    .din   (DOB),
    .pop   (fifo_pop),
    .dout  (out_data),
    .valid (out_valid),
    .count (fifo_count)
  );

  assign external = busy;
  assign err      = err_q;
  assign BRAM_i   = bi_q;
  assign BRAM_j   = bj_q;
  assign WEA      = wea_q;
  assign ADDRA    = addra_q;
  assign DIA      = dia_q;
  assign ADDRB    = addr_q;
  assign WEB      = 1'b0;
  assign DIB      = '0;

endmodule

// File: tb/tb_tile_bram_loader.sv
module tb_tile_bram_loader;

  localparam int TD = 2;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [7:0]    cmd_bi, cmd_bj;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          external;
  logic [7:0]    BRAM_i, BRAM_j;
  logic          WEA, WEB;
  logic [AW-1:0] ADDRA, ADDRB;
  logic [DW-1:0] DIA, DIB, DOB;
  logic          busy, done, err;

  always #5 clk = ~clk;

  tile_bram_loader #(.TILE_DIM(TD), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bi(cmd_bi), .cmd_bj(cmd_bj), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .external(external), .BRAM_i(BRAM_i), .BRAM_j(BRAM_j),
    .WEA(WEA), .WEB(WEB), .ADDRA(ADDRA), .ADDRB(ADDRB),
    .DIA(DIA), .DIB(DIB), .DOB(DOB),
    .busy(busy), .done(done), .err(err)
  );

  // Block BRAMs of the tile, indexed by {bi, bj, addr}; synchronous read.
  logic [DW-1:0] bram [0:4095];
  always @(posedge clk) begin
    if (WEA) bram[{BRAM_i[0], BRAM_j[0], ADDRA}] <= DIA;
    DOB <= bram[{BRAM_i[0], BRAM_j[0], ADDRB}];
  end

  // Bench's own record of what each block should contain.
  logic [DW-1:0] exp_mem [0:4095];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        op;
    logic [7:0]  bi;
    logic [7:0]  bj;
    logic [9:0]  base;
    logic [10:0] len;
    logic [15:0] seed;
    logic        stall;
    logic        bad;
  } vec_t;

  vec_t vecs[13];

  // Sampled on the falling edge while reset effects are settled.
  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_in_ready"},  in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_external"},  external, 0);
    chk({tag, "_bram_i"},    BRAM_i, 0);
    chk({tag, "_bram_j"},    BRAM_j, 0);
    chk({tag, "_wea"},       WEA, 0);
    chk({tag, "_web"},       WEB, 0);
    chk({tag, "_addra"},     ADDRA, 0);
    chk({tag, "_addrb"},     ADDRB, 0);
    chk({tag, "_dia"},       DIA, 0);
    chk({tag, "_dib"},       DIB, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_err"},       err, 0);
  endtask

  // Entered and left just after a rising edge.
  task automatic run_cmd(input vec_t v);
    int ws, nw, nb, first_beat, last_beat, done_cyc, done_cnt, done_k, budget, k;
    logic          hold_pend;
    logic [DW-1:0] hold_data;
    logic [11:0]   idx;
    ws = 0; nw = 0; nb = 0; first_beat = -1; last_beat = -1;
    done_cyc = -1; done_cnt = 0; done_k = -1; hold_pend = 1'b0; hold_data = '0;

    cmd_valid = 1'b1; cmd_op = v.op; cmd_bi = v.bi; cmd_bj = v.bj;
    cmd_base = v.base; cmd_len = v.len;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    if (v.bad) begin
      @(negedge clk);
      chk("bad_err_pulse", err, 1);
      chk("bad_external", external, 0);
      chk("bad_cmd_ready", cmd_ready, 1);
      chk("bad_busy", busy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bad_err_single", err, 0);
      chk("bad_cmd_ready2", cmd_ready, 1);
      @(posedge clk); #1;
      return;
    end

    budget = 4 * int'(v.len) + 20;
    for (k = 0; k < budget && done_cnt == 0; k++) begin
      in_valid  = (v.op == 1'b0);
      in_data   = v.seed + 16'(ws);
      out_ready = v.stall ? (k % 3 == 0) : 1'b1;
      @(negedge clk);
      if (k == 0 && v.len != 0) begin
        chk("external_high", external, 1);
        chk("bram_i_latched", BRAM_i, v.bi);
        chk("bram_j_latched", BRAM_j, v.bj);
      end
      if (in_valid && in_ready) ws++;
      if (WEA) begin
        if (nw < int'(v.len)) begin
          chk("wr_addr", ADDRA, 32'(10'(v.base + 10'(nw))));
          chk("wr_data", DIA, 32'(v.seed + 16'(nw)));
        end
        nw++;
      end
      if (hold_pend) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_data);
        hold_pend = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          idx = {v.bi[0], v.bj[0], 10'(v.base + 10'(nb))};
          if (nb < int'(v.len)) chk("dump_data", out_data, exp_mem[idx]);
          nb++;
          if (first_beat < 0) first_beat = cyc;
          last_beat = cyc;
        end else begin
          hold_pend = 1'b1;
          hold_data = out_data;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_k   = k;
        chk("wea_in_done", WEA, 0);
        chk("external_in_done", external, 1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    chk("done_seen", done_cnt, 1);
    @(negedge clk);
    chk("post_external", external, 0);
    chk("post_busy", busy, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_done_single", done, 0);

    if (v.len == 0) begin
      chk("len0_latency", (done_k >= 0 && done_k <= 1), 1);
      chk("len0_no_write", nw, 0);
      chk("len0_no_beat", nb, 0);
    end else if (v.op == 1'b0) begin
      chk("write_count", nw, v.len);
      for (int i = 0; i < int'(v.len); i++)
        exp_mem[{v.bi[0], v.bj[0], 10'(v.base + 10'(i))}] = v.seed + 16'(i);
    end else begin
      chk("beat_count", nb, v.len);
      chk("done_after_last", done_cyc, last_beat + 1);
      if (!v.stall) chk("burst_span", last_beat - first_beat, int'(v.len) - 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t r;
    vecs[0]  = '{1'b0, 8'd0,   8'd0, 10'h3FE, 11'd4,    16'h00A0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'd0,   8'd0, 10'h3FE, 11'd4,    16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'd1,   8'd1, 10'h100, 11'd8,    16'h5500, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'd1,   8'd1, 10'h100, 11'd8,    16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'd0,   8'd0, 10'h3FE, 11'd4,    16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'd2,   8'd0, 10'h000, 11'd4,    16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'd0,   8'd2, 10'h000, 11'd4,    16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'd0,   8'd0, 10'h050, 11'd0,    16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'd1,   8'd1, 10'h100, 11'd0,    16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'd0,   8'd1, 10'h3FF, 11'd1024, 16'h1000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'd0,   8'd1, 10'h3FF, 11'd1024, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'd0,   8'd1, 10'h3FF, 11'd3,    16'h0000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'hFF,  8'd0, 10'h000, 11'd2,    16'h0000, 1'b0, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_bi = '0; cmd_bj = '0;
    cmd_base = '0; cmd_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_cmd(vecs[i]);

    // Reset while the third of six LOAD words is on offer.
    r = '{1'b0, 8'd1, 8'd0, 10'h200, 11'd6, 16'h7700, 1'b0, 1'b0};
    cmd_valid = 1'b1; cmd_op = r.op; cmd_bi = r.bi; cmd_bj = r.bj;
    cmd_base = r.base; cmd_len = r.len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = r.seed;
    @(posedge clk); #1;
    in_data = r.seed + 16'd1;
    @(posedge clk); #1;
    in_data = r.seed + 16'd2;
    @(negedge clk);
    chk("abort_mid_busy", busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check_reset_vals("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk); #1;
    run_cmd(r);
    r = '{1'b1, 8'd1, 8'd0, 10'h200, 11'd6, 16'h0000, 1'b1, 1'b0};
    run_cmd(r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
